uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver, the counterpart of the board's UART transmitter. It samples the `rx` line at 16x the baud rate, recovers 8N1 frames (start bit, 8 data bits LSB first, stop bit) and presents each received byte with a one-cycle valid strobe. It sits between the FPGA pin (through its own synchronizer) and the design logic that consumes decoded bytes.

## Interface
Parameters:
- `BAUD`, default 9600: line bit rate in bit/s.
- `F`, default 50000000: `clk` frequency in Hz.

Ports:
- `clk` input 1: system clock, the only clock.
- `rst` input 1: reset, asynchronous, active-low.
- `rx` input 1: serial line, asynchronous to `clk`, idles high.
- `data` output 8: last good received byte. Resets to 0x00.
- `valid` output 1: one-cycle strobe, high when `data` has just been updated. Resets to 0.
- `frame_err` output 1: one-cycle strobe, high when the stop bit was sampled low. Resets to 0.
- `busy` output 1: high in every state except IDLE. Resets to 0.

## Operation
- `rx` passes through a 2-flop synchronizer; reset value of both flops is 1. The FSM sees only the synchronized signal `rx_s`.
- Oversample divisor: `DIV = F/(BAUD*16)`, integer truncation; 325 at the defaults. Precondition: `DIV >= 2`.
- Prescaler counts 0..DIV-1 and emits `tick` on wrap. It is held at 0 in IDLE, so the first tick comes DIV clocks after the start edge.
- FSM states and transitions:
  - IDLE: wait for `rx_s`==0, then go to START and clear the tick count.
  - START: on tick 8 (mid-bit), if `rx_s`==1 the start was a glitch: go to IDLE with no strobe. Otherwise clear the tick count and go to DATA.
  - DATA: every 16th tick, shift `rx_s` into the shift register MSB-side (LSB is received first). After bit 7, go to STOP.
  - STOP: on the 16th tick, sample the stop bit.
    - `rx_s`==1: load `data`, pulse `valid`, go to IDLE.
    - `rx_s`==0: pulse `frame_err`, leave `data` unchanged, go to BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE. This prevents a held-low line from being decoded as 0x00 frames.
- `valid` and `frame_err` are never high in the same cycle.
- Back-to-back frames are supported. IDLE is entered at mid-stop-bit, so a start edge that immediately follows the stop bit is caught.
- Asynchronous reset at any point clears all state and outputs. A frame interrupted by reset is discarded with no strobe.

## Timing
- Synchronizer latency: 2 clk.
- Mid-start confirmation: 8·DIV clk after the falling edge is seen on `rx_s`.
- Each data bit is sampled 16·DIV clk after the previous sample point.
- `valid`/`frame_err` are registered. They rise in the clk cycle after the stop-bit sample tick and last exactly 1 clk.
- `data` changes in the same cycle `valid` rises and holds until the next good frame.
- Edge-to-strobe latency from the `rx` falling edge: 2 + 8·DIV + 9·16·DIV + 1 clk, ±1 clk for edge phase.

## Configuration
- `UART_RX_ASCII_EN` defined: the byte loaded into `data` is `rx_byte - 8'd48`, with modulo-256 wrap. This undoes the transmitter's ASCII-digit offset, so a received '7' (0x37) gives 0x07.
- Not defined: `data` is the raw received byte.
- Framing, timing and strobes are identical in both builds.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum: IDLE, START, DATA, STOP, BREAK.
  - Constants: `OVERSAMPLE`=16, `MID_TICK`=8, `DATA_BITS`=8, `ASCII_OFFSET`=8'd48.
  - The transmitter also uses this package.
- Sub-module `uart_baud_gen`: parameterised prescaler with `clk`, `rst`, synchronous `clr`, and `tick` output. The FSM, synchronizer and shift register stay in `uart_rx`.

## Test plan
Use `F`=1600000 and `BAUD`=10000, so DIV=10 and 1 bit = 160 clk.

- **Single frame:** send 0x35 as an ideal 8N1 frame. Expect one `valid` pulse with `data`=0x35, or `data`=0x05 when `UART_RX_ASCII_EN` is defined; `frame_err` stays 0.
- **Back-to-back:** send 0xA5 then 0x3C with zero idle gap. Expect two `valid` pulses 1600±2 clk apart with `data` 0xA5 then 0x3C.
- **Glitch rejection:** drive `rx` low for 40 clk, then high. Expect no strobe, `busy` back to 0 within 130 clk, and `data` unchanged.
- **Framing error:** send 0x55 with the stop bit low, held low for 5 more bit times, then high. Expect one `frame_err` pulse, no `valid`, `data` keeping its prior value, and no further strobes while the line is low.
- **Reset mid-frame:** assert `rst` low during data bit 4, release, then send 0x81. Expect outputs at their reset values during reset, no strobe for the aborted frame, and then `valid` with `data`=0x81.
- **Baud tolerance:** send 0xC3 with bit period 166 clk (+3.75%). Expect `valid` with `data`=0xC3.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and framing constants.
// Used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    localparam int          OVERSAMPLE   = 16;
    localparam int          MID_TICK     = 8;
    localparam int          DATA_BITS    = 8;
    localparam logic [7:0]  ASCII_OFFSET = 8'd48;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample prescaler: counts 0..DIV-1 and pulses tick on the wrap.
// Synchronous clr holds the count at 0.
module uart_baud_gen #(
    parameter int DIV = 325
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = !clr && (cnt_q == CW'(DIV - 1));
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, glitch rejection and break hold-off.
// Build option: UART_RX_ASCII_EN subtracts the ASCII '0' offset from each good byte.
//
// state | meaning
// IDLE  | line idle, prescaler held, waiting for a low rx_s
// START | counting to mid start bit, rejects glitches
// DATA  | sampling 8 data bits, LSB first, one per 16 ticks
// STOP  | sampling stop bit: good byte or framing error
// BREAK | line held low after framing error, wait for release
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD = 9600,
    parameter int F    = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV = F / (BAUD * OVERSAMPLE);

    uart_state_e state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [3:0]  tcnt_q, tcnt_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        tick;
    logic [7:0]  byte_out;

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == IDLE),
        .tick (tick)
    );

`ifdef UART_RX_ASCII_EN
    assign byte_out = shift_q - ASCII_OFFSET;
`else
    assign byte_out = shift_q;
`endif

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tcnt_d = 4'(MID_TICK - 1);
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (tick) begin
                    if (tcnt_q == 4'd0) begin
                        if (rx_s_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            tcnt_d  = 4'(OVERSAMPLE - 1);
                            bcnt_d  = 3'd0;
                        end
                    end else begin
                        tcnt_d = tcnt_q - 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tcnt_q == 4'd0) begin
                        shift_d = {rx_s_q, shift_q[7:1]};
                        tcnt_d  = 4'(OVERSAMPLE - 1);
                        if (bcnt_q == 3'(DATA_BITS - 1)) state_d = STOP;
                        else bcnt_d = bcnt_q + 3'd1;
                    end else begin
                        tcnt_d = tcnt_q - 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tcnt_q == 4'd0) begin
                        if (rx_s_q) begin
                            data_d  = byte_out;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        tcnt_d = tcnt_q - 4'd1;
                    end
                end
            end
            BREAK: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=10 (160 clk per bit).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int edge_cyc = 0;
    int valid_cnt = 0;
    int fe_cnt = 0;
    int vcyc[$];
    logic [7:0] vdata [$];
    logic prev_valid = 1'b0;

    uart_rx #(.BAUD(10000), .F(1600000)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            vcyc.push_back(cyc);
            vdata.push_back(data);
        end
        if (frame_err) fe_cnt++;
        if (valid || frame_err) begin
            tests++;
            if (valid && frame_err) begin
                fails++;
                $display("FAIL strobe_overlap: valid and frame_err both high at cycle %0d", cyc);
            end
        end
        if (valid && prev_valid) begin
            tests++;
            fails++;
            $display("FAIL valid_width: valid high for more than 1 clk at cycle %0d", cyc);
        end
        prev_valid = valid;
    end

    function automatic logic [7:0] exp_byte(input logic [7:0] b);
`ifdef UART_RX_ASCII_EN
        return b - 8'd48;
`else
        return b;
`endif
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int per);
        edge_cyc = cyc;
        rx = 1'b0;
        wait_cyc(per);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(per);
        end
        rx = stop_v;
        wait_cyc(per);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx  = 1'b1;
        wait_cyc(3);
        tests++;
        if ({data, valid, frame_err, busy} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs: got data=%h valid=%b ferr=%b busy=%b, want 00 0 0 0",
                     data, valid, frame_err, busy);
        end
        rst = 1'b1;
        wait_cyc(20);
        tests++;
        if (busy !== 1'b0 || valid_cnt != 0) begin
            fails++;
            $display("FAIL idle_after_reset: busy=%b valid_cnt=%0d, want 0 0", busy, valid_cnt);
        end
    endtask

    task automatic test_single_frame();
        int v0, f0, lat;
        v0 = valid_cnt;
        f0 = fe_cnt;
        send_frame(8'h35, 1'b1, 160);
        wait_cyc(100);
        tests++;
        if (valid_cnt - v0 != 1) begin
            fails++;
            $display("FAIL single_count: got %0d valid pulses, want 1", valid_cnt - v0);
        end else begin
            tests++;
            if (vdata[v0] !== exp_byte(8'h35)) begin
                fails++;
                $display("FAIL single_data: got %h, want %h", vdata[v0], exp_byte(8'h35));
            end
            lat = vcyc[v0] - edge_cyc;
            tests++;
            if (lat < 1522 || lat > 1524) begin
                fails++;
                $display("FAIL single_latency: got %0d clk, want 1523+-1", lat);
            end
        end
        tests++;
        if (fe_cnt != f0) begin
            fails++;
            $display("FAIL single_ferr: got %0d frame_err pulses, want 0", fe_cnt - f0);
        end
    endtask

    task automatic test_back_to_back();
        int v0, gap;
        v0 = valid_cnt;
        send_frame(8'hA5, 1'b1, 160);
        send_frame(8'h3C, 1'b1, 160);
        wait_cyc(100);
        tests++;
        if (valid_cnt - v0 != 2) begin
            fails++;
            $display("FAIL b2b_count: got %0d valid pulses, want 2", valid_cnt - v0);
        end else begin
            tests++;
            if (vdata[v0] !== exp_byte(8'hA5) || vdata[v0+1] !== exp_byte(8'h3C)) begin
                fails++;
                $display("FAIL b2b_data: got %h %h, want %h %h", vdata[v0], vdata[v0+1],
                         exp_byte(8'hA5), exp_byte(8'h3C));
            end
            gap = vcyc[v0+1] - vcyc[v0];
            tests++;
            if (gap < 1598 || gap > 1602) begin
                fails++;
                $display("FAIL b2b_spacing: got %0d clk, want 1600+-2", gap);
            end
        end
    endtask

    task automatic test_glitch();
        int v0, f0, n;
        logic [7:0] d0;
        v0 = valid_cnt;
        f0 = fe_cnt;
        d0 = data;
        rx = 1'b0;
        wait_cyc(20);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL glitch_busy_high: got busy=%b, want 1", busy);
        end
        wait_cyc(20);
        rx = 1'b1;
        n = 40;
        while (busy !== 1'b0 && n < 130) begin
            wait_cyc(1);
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL glitch_busy_release: busy=%b after %0d clk, want 0 within 130", busy, n);
        end
        wait_cyc(200);
        tests++;
        if (valid_cnt != v0 || fe_cnt != f0 || data !== d0) begin
            fails++;
            $display("FAIL glitch_no_strobe: valid=%0d ferr=%0d data=%h, want 0 0 %h",
                     valid_cnt - v0, fe_cnt - f0, data, d0);
        end
    endtask

    task automatic test_frame_err();
        int v0, f0;
        logic [7:0] d0;
        v0 = valid_cnt;
        f0 = fe_cnt;
        d0 = data;
        send_frame(8'h55, 1'b0, 160);
        wait_cyc(800);
        tests++;
        if (fe_cnt - f0 != 1 || valid_cnt != v0) begin
            fails++;
            $display("FAIL ferr_strobes: got ferr=%0d valid=%0d, want 1 0", fe_cnt - f0, valid_cnt - v0);
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL ferr_break_busy: got busy=%b while line low, want 1", busy);
        end
        rx = 1'b1;
        wait_cyc(10);
        tests++;
        if (busy !== 1'b0 || data !== d0) begin
            fails++;
            $display("FAIL ferr_release: busy=%b data=%h, want 0 %h", busy, data, d0);
        end
        wait_cyc(200);
        tests++;
        if (fe_cnt - f0 != 1 || valid_cnt != v0) begin
            fails++;
            $display("FAIL ferr_no_more: got ferr=%0d valid=%0d, want 1 0", fe_cnt - f0, valid_cnt - v0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        logic [7:0] b;
        b = 8'h81;
        v0 = valid_cnt;
        rx = 1'b0;
        wait_cyc(160);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_cyc(160);
        end
        rx = b[4];
        wait_cyc(80);
        rst = 1'b0;
        wait_cyc(2);
        tests++;
        if ({data, valid, frame_err, busy} !== 11'd0) begin
            fails++;
            $display("FAIL midreset_outputs: got data=%h valid=%b ferr=%b busy=%b, want 00 0 0 0",
                     data, valid, frame_err, busy);
        end
        rx = 1'b1;
        wait_cyc(20);
        rst = 1'b1;
        wait_cyc(200);
        tests++;
        if (valid_cnt != v0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_discard: valid=%0d busy=%b, want 0 0", valid_cnt - v0, busy);
        end
        send_frame(8'h81, 1'b1, 160);
        wait_cyc(100);
        tests++;
        if (valid_cnt - v0 != 1 || data !== exp_byte(8'h81)) begin
            fails++;
            $display("FAIL midreset_recover: valid=%0d data=%h, want 1 %h",
                     valid_cnt - v0, data, exp_byte(8'h81));
        end
    endtask

    task automatic test_baud_tol();
        int v0, f0;
        v0 = valid_cnt;
        f0 = fe_cnt;
        send_frame(8'hC3, 1'b1, 166);
        wait_cyc(100);
        tests++;
        if (valid_cnt - v0 != 1 || fe_cnt != f0 || data !== exp_byte(8'hC3)) begin
            fails++;
            $display("FAIL baud_tol: valid=%0d ferr=%0d data=%h, want 1 0 %h",
                     valid_cnt - v0, fe_cnt - f0, data, exp_byte(8'hC3));
        end
    endtask

    initial begin
        wait_cyc(1);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_baud_tol();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
